// File: rtl/prelude_loader.sv
// UART boot loader: receives 0xA5, N, N data bytes and writes them to program memory while holding the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte after the data.
module prelude_loader #(
   parameter int CLKS_PER_BIT = 234
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_hold,
   output logic       done,
   output logic       error
);

   localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM} frame_state_t;

   logic         rx_meta;
   logic         rx_sync;
   rx_state_t    rx_state;
   logic [15:0]  clk_cnt;
   logic [2:0]   bit_idx;
   logic [7:0]   shift;
   logic         armed;
   logic         byte_valid;
   logic         frame_err;

   frame_state_t frame_state;
   logic [8:0]   remaining;
   logic [7:0]   addr_cnt;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]   sum;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // armed only goes high after rx_sync is seen high in idle, so a start bit is a true falling edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state   <= RX_IDLE;
         clk_cnt    <= 16'd0;
         bit_idx    <= 3'd0;
         shift      <= 8'd0;
         armed      <= 1'b0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               armed <= rx_sync;
               if (armed && !rx_sync) begin
                  rx_state <= RX_START;
                  clk_cnt  <= 16'd0;
               end
            end
            RX_START: begin
               armed <= 1'b0;
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt <= 16'd0;
                  if (rx_sync) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_state <= RX_DATA;
                     bit_idx  <= 3'd0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= 16'd0;
                  shift   <= {rx_sync, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     rx_state <= RX_STOP;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt  <= 16'd0;
                  rx_state <= RX_IDLE;
                  if (rx_sync) begin
                     byte_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // shift stays stable outside RX_DATA, so it is the received byte while byte_valid is high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_state <= WAIT_SYNC;
         remaining   <= 9'd0;
         addr_cnt    <= 8'd0;
         mem_we      <= 1'b0;
         mem_addr    <= 8'd0;
         mem_wdata   <= 8'd0;
         cpu_hold    <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum         <= 8'd0;
`endif
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         if (frame_err && frame_state != WAIT_SYNC) begin
            error       <= 1'b1;
            frame_state <= WAIT_SYNC;
         end else if (byte_valid) begin
            case (frame_state)
               WAIT_SYNC: begin
                  if (shift == 8'hA5) begin
                     frame_state <= GET_LEN;
                     cpu_hold    <= 1'b1;
                     error       <= 1'b0;
                     addr_cnt    <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
                     sum         <= 8'd0;
`endif
                  end
               end
               GET_LEN: begin
                  remaining   <= (shift == 8'd0) ? 9'd256 : {1'b0, shift};
                  frame_state <= GET_DATA;
               end
               GET_DATA: begin
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_cnt;
                  mem_wdata <= shift;
                  addr_cnt  <= addr_cnt + 8'd1;
                  remaining <= remaining - 9'd1;
`ifdef LOADER_CHECKSUM_EN
                  sum       <= sum + shift;
                  if (remaining == 9'd1) begin
                     frame_state <= GET_SUM;
                  end
`else
                  if (remaining == 9'd1) begin
                     done        <= 1'b1;
                     cpu_hold    <= 1'b0;
                     frame_state <= WAIT_SYNC;
                  end
`endif
               end
               GET_SUM: begin
`ifdef LOADER_CHECKSUM_EN
                  if (shift == sum) begin
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     error    <= 1'b1;
                  end
`endif
                  frame_state <= WAIT_SYNC;
               end
               default: frame_state <= WAIT_SYNC;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prelude_loader.sv
// Scoreboard bench for prelude_loader: stimulus pushes expected writes/done, a monitor pops them.
module tb_prelude_loader;

   localparam int CPB = 4;

   logic       clk;
   logic       reset;
   logic       rx;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_hold;
   logic       done;
   logic       error;

   typedef struct packed {
      logic       isWrite;
      logic [7:0] addr;
      logic [7:0] data;
      logic       withDone;
   } exp_t;

   exp_t       expQ[$];
   logic [7:0] frameData[$];
   int         total = 0;
   int         bad = 0;

   prelude_loader #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .reset(reset),
      .rx(rx),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold),
      .done(done),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One 8N1 character, LSB first; stopBit=0 produces a framing error
   task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int gap);
      logic [7:0] v;
      v = b;
      @(negedge clk);
      rx = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = v[i];
         waitCycles(CPB);
      end
      rx = stopBit;
      waitCycles(CPB);
      rx = 1'b1;
      waitCycles(gap);
   endtask

   task automatic pushWrite(input int a, input logic [7:0] d, input logic last);
      exp_t e;
      e.isWrite  = 1'b1;
      e.addr     = 8'(a);
      e.data     = d;
      e.withDone = last;
      expQ.push_back(e);
   endtask

   task automatic pushDone();
      exp_t e;
      e.isWrite  = 1'b0;
      e.addr     = 8'd0;
      e.data     = 8'd0;
      e.withDone = 1'b1;
      expQ.push_back(e);
   endtask

   // Sends a complete good frame built from frameData; nField is the length byte (0 means 256)
   task automatic sendFrame(input int nField, input int maxGap);
      int cnt;
      int sumAcc;
      cnt = (nField == 0) ? 256 : nField;
      sumAcc = 0;
      for (int i = 0; i < cnt; i++) begin
         sumAcc = (sumAcc + int'(frameData[i])) % 256;
`ifdef LOADER_CHECKSUM_EN
         pushWrite(i % 256, frameData[i], 1'b0);
`else
         pushWrite(i % 256, frameData[i], i == cnt - 1);
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      pushDone();
`endif
      applyStimulus(8'hA5, 1'b1, 6);
      checkOutput("hold after sync", 32'(cpu_hold), 1);
      checkOutput("error cleared by sync", 32'(error), 0);
      applyStimulus(8'(nField), 1'b1, $urandom_range(1, maxGap));
      for (int i = 0; i < cnt; i++) begin
         applyStimulus(frameData[i], 1'b1, $urandom_range(1, maxGap));
      end
`ifdef LOADER_CHECKSUM_EN
      applyStimulus(8'(sumAcc), 1'b1, 2);
`endif
      waitCycles(12);
      checkOutput("hold after load", 32'(cpu_hold), 0);
      checkOutput("error after load", 32'(error), 0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " mem_we"}, 32'(mem_we), 0);
      checkOutput({tag, " mem_addr"}, 32'(mem_addr), 0);
      checkOutput({tag, " mem_wdata"}, 32'(mem_wdata), 0);
      checkOutput({tag, " cpu_hold"}, 32'(cpu_hold), 0);
      checkOutput({tag, " done"}, 32'(done), 0);
      checkOutput({tag, " error"}, 32'(error), 0);
   endtask

   // Monitor: every write or done pulse must match the head of the expectation queue
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_we || done) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected output: mem_we=%0b addr=%0h data=%0h done=%0b, required none",
                        mem_we, mem_addr, mem_wdata, done);
            end else begin
               e = expQ.pop_front();
               if (e.isWrite) begin
                  checkOutput("write strobe", 32'(mem_we), 1);
                  checkOutput("write addr", 32'(mem_addr), 32'(e.addr));
                  checkOutput("write data", 32'(mem_wdata), 32'(e.data));
                  checkOutput("done with write", 32'(done), 32'(e.withDone));
               end else begin
                  checkOutput("done pulse", 32'(done), 1);
                  checkOutput("no write with sum done", 32'(mem_we), 0);
               end
               checkOutput("hold vs done", 32'(cpu_hold), 32'(!done));
            end
         end
      end
   end

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] partial;
      logic [7:0] b;
      rx = 1'b1;
      reset = 1'b0;
      waitCycles(3);
      checkResetValues("reset");
      reset = 1'b1;
      waitCycles(5);

      $display("[TB] basic three-byte load with leading junk");
      applyStimulus(8'h12, 1'b1, 12);
      checkOutput("junk ignored hold", 32'(cpu_hold), 0);
      frameData = '{8'h01, 8'h02, 8'h03};
      sendFrame(3, 2);

      $display("[TB] one-cycle glitch while idle");
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      waitCycles(20);
      checkOutput("glitch hold", 32'(cpu_hold), 0);
      checkOutput("glitch error", 32'(error), 0);

      $display("[TB] framing error in data phase");
      pushWrite(0, 8'hAA, 1'b0);
      applyStimulus(8'hA5, 1'b1, 2);
      applyStimulus(8'h04, 1'b1, 2);
      applyStimulus(8'hAA, 1'b1, 2);
      applyStimulus(8'h3C, 1'b0, 6);
      applyStimulus(8'h55, 1'b1, 12);
      checkOutput("framing error flag", 32'(error), 1);
      checkOutput("framing error hold", 32'(cpu_hold), 1);
      frameData = '{8'hDE, 8'hAD};
      sendFrame(2, 3);

`ifdef LOADER_CHECKSUM_EN
      $display("[TB] checksum mismatch then good frame");
      pushWrite(0, 8'h10, 1'b0);
      pushWrite(1, 8'h20, 1'b0);
      applyStimulus(8'hA5, 1'b1, 2);
      applyStimulus(8'h02, 1'b1, 2);
      applyStimulus(8'h10, 1'b1, 2);
      applyStimulus(8'h20, 1'b1, 2);
      applyStimulus(8'h31, 1'b1, 12);
      checkOutput("checksum error flag", 32'(error), 1);
      checkOutput("checksum error hold", 32'(cpu_hold), 1);
      frameData = '{8'h7F};
      sendFrame(1, 2);
`endif

      $display("[TB] 256-byte load with address wrap");
      frameData.delete();
      for (int i = 0; i < 256; i++) frameData.push_back(8'(i));
      sendFrame(0, 1);

      $display("[TB] reset in the middle of a load");
      pushWrite(0, 8'h5A, 1'b0);
      applyStimulus(8'hA5, 1'b1, 2);
      applyStimulus(8'h04, 1'b1, 2);
      applyStimulus(8'h5A, 1'b1, 2);
      partial = 8'hC3;
      @(negedge clk);
      rx = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < 3; i++) begin
         rx = partial[i];
         waitCycles(CPB);
      end
      #2;
      reset = 1'b0;
      #1;
      checkResetValues("async reset");
      checkOutput("first byte written before reset", expQ.size(), 0);
      waitCycles(10);
      rx = 1'b1;
      waitCycles(5);
      reset = 1'b1;
      waitCycles(10);
      frameData = '{8'h11, 8'h22, 8'h33, 8'h44};
      sendFrame(4, 2);

      $display("[TB] randomized frames");
      for (int f = 0; f < 6; f++) begin
         int n;
         int junk;
         junk = $urandom_range(0, 2);
         for (int j = 0; j < junk; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            applyStimulus(b, 1'b1, $urandom_range(1, 3));
         end
         n = $urandom_range(1, 20);
         frameData.delete();
         for (int i = 0; i < n; i++) frameData.push_back(8'($urandom_range(0, 255)));
         sendFrame(n, 3);
      end

      waitCycles(20);
      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prelude_loader.md
PRELUDE_LOADER -- requirements
Module: prelude_loader

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 234, giving clk cycles per UART bit (27 MHz / 115200); legal range 4..65535.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004 rx  input  1  UART serial in, 8N1, LSB first, idle high; asynchronous to clk.
REQ-005 mem_we  output  1  program-memory write strobe, one-cycle pulse per data byte.
REQ-006 mem_addr  output  8  program-memory write address.
REQ-007 mem_wdata  output  8  program-memory write data.
REQ-008 cpu_hold  output  1  high while a load is in progress; drives the CPU reset.
REQ-009 done  output  1  one-cycle pulse on successful load completion.
REQ-010 error  output  1  sticky load-failure flag.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-012 Bit FSM: RX_IDLE -> RX_START on sync'd rx falling to 0; RX_START resamples at CLKS_PER_BIT/2 (integer divide); 1 there -> RX_IDLE (glitch, no byte).
REQ-013 RX_DATA samples 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint, LSB first; RX_STOP samples the stop bit one interval later.
REQ-014 Stop sample 1 -> byte accepted (internal byte_valid for exactly one cycle); stop sample 0 -> framing error, byte discarded; both return to RX_IDLE.
REQ-015 Frame FSM: WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM; advances only on accepted bytes.
REQ-016 WAIT_SYNC: byte 0xA5 -> GET_LEN, set cpu_hold=1, clear error, clear checksum accumulator, clear address counter; any other byte ignored.
REQ-017 GET_LEN: byte N stored as remaining count; N=0x00 means 256 bytes; -> GET_DATA.
REQ-018 GET_DATA: each byte SHALL produce mem_we=1 for exactly one cycle, in the cycle after byte_valid, with mem_addr = address counter, mem_wdata = byte; counter then increments mod 256 and checksum += byte mod 256.
REQ-019 Last data byte: -> GET_SUM when LOADER_CHECKSUM_EN is defined, else completion (REQ-020).
REQ-020 Completion: done=1 for one cycle coincident with mem_we of the last byte (or the cycle after the checksum byte's byte_valid); cpu_hold falls on the same edge done rises; -> WAIT_SYNC.
REQ-021 Framing error in any state other than WAIT_SYNC: error=1, cpu_hold stays 1, -> WAIT_SYNC; in WAIT_SYNC framing errors are ignored.
REQ-022 A new 0xA5 after completion or failure SHALL start a fresh load (REQ-016).
REQ-023 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-024 On reset low: mem_we=0, mem_addr=0x00, mem_wdata=0x00, cpu_hold=0, done=0, error=0, bit FSM RX_IDLE, frame FSM WAIT_SYNC, counters 0.
REQ-025 Reset asserted mid-load SHALL abandon the load with no further mem_we pulses; already-written bytes are not undone.
REQ-026 After reset deasserts, the first start bit is recognised only once sync'd rx has been observed high.

Configuration
REQ-027 Macro LOADER_CHECKSUM_EN defined: frame = 0xA5, N, data, checksum; checksum byte equal to the 8-bit data sum -> completion; mismatch -> error=1, no done, cpu_hold stays 1, -> WAIT_SYNC.
REQ-028 LOADER_CHECKSUM_EN undefined: frame = 0xA5, N, data; no checksum byte consumed; accumulator logic absent.

Verification (CLKS_PER_BIT=4)
REQ-029 Send 0x12, 0xA5, 0x03, 0x01, 0x02, 0x03, [0x06] -> three mem_we pulses at addr 0,1,2 with data 01,02,03; one done pulse; cpu_hold high from 0xA5 until done; error=0; 0x12 causes nothing.
REQ-030 With checksum enabled, send 0xA5, 0x02, 0x10, 0x20, 0x31 -> two writes, no done, error=1, cpu_hold=1; then valid frame 0xA5, 0x01, 0x7F, 0x7F -> error clears on 0xA5, done pulses, cpu_hold=0.
REQ-031 Send 0xA5, 0x00, then bytes 0x00..0xFF [checksum 0x80] -> 256 writes, addr 0x00..0xFF then counter wraps to 0x00, single done.
REQ-032 Send 0xA5, 0x04, 0xAA, then a byte with stop bit 0 -> one write, error=1, cpu_hold=1, FSM in WAIT_SYNC (next 0x55 ignored).
REQ-033 Assert reset low mid-bit of the 2nd data byte of a 4-byte load -> all outputs to REQ-024 values asynchronously, no further mem_we; a following full frame loads correctly.
REQ-034 Pulse rx low for 1 cycle while idle -> no byte accepted, no output change.
